// File: rtl/traffic_pkg.sv
// Shared types for the demand-actuated intersection scheduler: lamp codes,
// phase encodings and the phase-to-lamp decode used by RTL and bench alike.
package traffic_pkg;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    M2_YELLOW   = 3'd1,
    TURN_GREEN  = 3'd2,
    TURN_YELLOW = 3'd3,
    MAIN_YELLOW = 3'd4,
    ALL_RED     = 3'd5,
    SIDE_GREEN  = 3'd6,
    SIDE_YELLOW = 3'd7
  } phase_t;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } lamps_t;

  // Unknown encodings fall back to the safe resting picture (main green).
  function automatic lamps_t lamp_decode(input phase_t p);
    lamps_t l;
    case (p)
      MAIN_GREEN:  l = {LAMP_G, LAMP_G, LAMP_R, LAMP_R};
      M2_YELLOW:   l = {LAMP_G, LAMP_Y, LAMP_R, LAMP_R};
      TURN_GREEN:  l = {LAMP_G, LAMP_R, LAMP_G, LAMP_R};
      TURN_YELLOW: l = {LAMP_Y, LAMP_R, LAMP_Y, LAMP_R};
      MAIN_YELLOW: l = {LAMP_Y, LAMP_Y, LAMP_R, LAMP_R};
      ALL_RED:     l = {LAMP_R, LAMP_R, LAMP_R, LAMP_R};
      SIDE_GREEN:  l = {LAMP_R, LAMP_R, LAMP_R, LAMP_G};
      SIDE_YELLOW: l = {LAMP_R, LAMP_R, LAMP_R, LAMP_Y};
      default:     l = {LAMP_G, LAMP_G, LAMP_R, LAMP_R};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_demand_scheduler_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_PER_TICK clocks; restart
// realigns the tick grid to the start of a new phase.
module tick_prescaler #(
  parameter int CLK_PER_TICK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(CLK_PER_TICK - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (restart || tick)
      count <= '0;
    else
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/traffic_demand_scheduler.sv
// Demand-actuated phase scheduler: rests in main green and serves the turn
// and side phases only when a latched request is waiting.
module traffic_demand_scheduler
  import traffic_pkg::*;
#(
  parameter int CLK_PER_TICK = 4,
  parameter int T_MAIN_MIN   = 7,
  parameter int T_YELLOW     = 2,
  parameter int T_TURN       = 5,
  parameter int T_SIDE       = 3,
  parameter int T_ALLRED     = 1,
  parameter int TMR_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_turn,
  input  logic       req_side,
  output logic [2:0] M1,
  output logic [2:0] M2,
  output logic [2:0] MT,
  output logic [2:0] S,
  output logic [2:0] phase,
  output logic       turn_pending,
  output logic       side_pending
);

  phase_t           state, state_next;
  logic             tick, restart, done, from_side;
  logic [TMR_W-1:0] timer, dur;
  lamps_t           lamps;

  assign restart = (state_next != state);

  tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    dur = TMR_W'(T_MAIN_MIN);
    case (state)
      MAIN_GREEN:  dur = TMR_W'(T_MAIN_MIN);
      TURN_GREEN:  dur = TMR_W'(T_TURN);
      SIDE_GREEN:  dur = TMR_W'(T_SIDE);
      ALL_RED:     dur = TMR_W'(T_ALLRED);
      M2_YELLOW, TURN_YELLOW, MAIN_YELLOW, SIDE_YELLOW:
                   dur = TMR_W'(T_YELLOW);
      default:     dur = TMR_W'(T_MAIN_MIN);
    endcase
  end

  // Expiry is seen on the last tick so the next phase starts exactly
  // T*CLK_PER_TICK cycles after entry; main green then holds it saturated.
  assign done = (timer == dur) || (tick && ((timer + TMR_W'(1)) == dur));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer <= '0;
    else if (restart)
      timer <= '0;
    else if (tick && (timer != dur))
      timer <= timer + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= MAIN_GREEN;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MAIN_GREEN:
        if (done && turn_pending)      state_next = M2_YELLOW;
        else if (done && side_pending) state_next = MAIN_YELLOW;
      M2_YELLOW:   if (done) state_next = TURN_GREEN;
      TURN_GREEN:  if (done) state_next = TURN_YELLOW;
      TURN_YELLOW: if (done) state_next = ALL_RED;
      MAIN_YELLOW: if (done) state_next = ALL_RED;
      ALL_RED:
        if (done) begin
          if (from_side)         state_next = MAIN_GREEN;
          else if (side_pending) state_next = SIDE_GREEN;
          else                   state_next = MAIN_GREEN;
        end
      SIDE_GREEN:  if (done) state_next = SIDE_YELLOW;
      SIDE_YELLOW: if (done) state_next = ALL_RED;
      default:     state_next = MAIN_GREEN;
    endcase
  end

  // Clearing on phase entry takes precedence over a request on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turn_pending <= 1'b0;
      side_pending <= 1'b0;
      from_side    <= 1'b0;
    end else begin
      if (state != TURN_GREEN && state_next == TURN_GREEN)
        turn_pending <= 1'b0;
      else if (req_turn && state != TURN_GREEN)
        turn_pending <= 1'b1;

      if (state != SIDE_GREEN && state_next == SIDE_GREEN)
        side_pending <= 1'b0;
      else if (req_side && state != SIDE_GREEN)
        side_pending <= 1'b1;

      if (state == SIDE_YELLOW && state_next == ALL_RED)
        from_side <= 1'b1;
      else if (state == ALL_RED && state_next != ALL_RED)
        from_side <= 1'b0;
    end
  end

  assign lamps = lamp_decode(state);
  assign M1    = lamps.m1;
  assign M2    = lamps.m2;
  assign MT    = lamps.mt;
  assign S     = lamps.s;
  assign phase = state;

endmodule

// File: tb/tb_traffic_demand_scheduler.sv
// Directed bench for traffic_demand_scheduler; cycle 0 is the clock period
// right after reset release, inputs change and outputs are sampled on negedge.
module tb_traffic_demand_scheduler;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_turn = 1'b0;
  logic       req_side = 1'b0;
  logic [2:0] M1, M2, MT, S, phase;
  logic       turn_pending, side_pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_demand_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .req_turn     (req_turn),
    .req_side     (req_side),
    .M1           (M1),
    .M2           (M2),
    .MT           (MT),
    .S            (S),
    .phase        (phase),
    .turn_pending (turn_pending),
    .side_pending (side_pending)
  );

  task automatic reset_dut();
    reset    = 1'b1;
    req_turn = 1'b0;
    req_side = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    tests++;
    if (phase !== 3'd0 || M1 !== 3'b001 || M2 !== 3'b001 || MT !== 3'b100 || S !== 3'b100) begin
      fails++;
      $display("[TB] FAIL reset_lamps: phase=%0d M1=%b M2=%b MT=%b S=%b, expected 0 001 001 100 100",
               phase, M1, M2, MT, S);
    end
    tests++;
    if (turn_pending !== 1'b0 || side_pending !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_pending: turn=%b side=%b, expected 0 0", turn_pending, side_pending);
    end
  endtask

  task automatic test_idle();
    reset_dut();
    for (int c = 0; c < 200; c++) begin
      tests++;
      if (phase !== 3'd0 || {M1, M2, MT, S} !== 12'b001_001_100_100 ||
          turn_pending !== 1'b0 || side_pending !== 1'b0) begin
        fails++;
        $display("[TB] FAIL idle cycle %0d: phase=%0d lamps=%b%b%b%b pend=%b%b, expected 0 001001100100 00",
                 c, phase, M1, M2, MT, S, turn_pending, side_pending);
      end
      next_cycle();
    end
  endtask

  task automatic test_turn();
    int     chg_c[6] = '{0, 28, 36, 56, 64, 68};
    phase_t chg_p[6] = '{MAIN_GREEN, M2_YELLOW, TURN_GREEN, TURN_YELLOW, ALL_RED, MAIN_GREEN};
    phase_t exp_p = MAIN_GREEN;
    logic [11:0] exp_l;
    int k = 0;
    reset_dut();
    for (int c = 0; c <= 80; c++) begin
      req_turn = (c == 3);
      if (k < 6 && c == chg_c[k]) begin exp_p = chg_p[k]; k++; end
      exp_l = lamp_decode(exp_p);
      tests++;
      if (phase !== exp_p || {M1, M2, MT, S} !== exp_l) begin
        fails++;
        $display("[TB] FAIL turn_seq cycle %0d: phase=%0d lamps=%h, expected phase=%0d lamps=%h",
                 c, phase, {M1, M2, MT, S}, exp_p, exp_l);
      end
      if (c == 3 || c == 4 || c == 36) begin
        tests++;
        if (turn_pending !== (c == 4)) begin
          fails++;
          $display("[TB] FAIL turn_pending cycle %0d: got %b, expected %b", c, turn_pending, (c == 4));
        end
      end
      if (c == 28) begin
        tests++;
        if (M2 !== 3'b010) begin
          fails++;
          $display("[TB] FAIL m2_yellow_lamp: M2=%b, expected 010", M2);
        end
      end
      if (c == 36) begin
        tests++;
        if (MT !== 3'b001 || M2 !== 3'b100) begin
          fails++;
          $display("[TB] FAIL turn_green_lamps: MT=%b M2=%b, expected 001 100", MT, M2);
        end
      end
      if (c == 56) begin
        tests++;
        if (M1 !== 3'b010 || MT !== 3'b010) begin
          fails++;
          $display("[TB] FAIL turn_yellow_lamps: M1=%b MT=%b, expected 010 010", M1, MT);
        end
      end
      next_cycle();
    end
    req_turn = 1'b0;
  endtask

  task automatic test_side();
    int     chg_c[7] = '{0, 41, 49, 53, 65, 73, 77};
    phase_t chg_p[7] = '{MAIN_GREEN, MAIN_YELLOW, ALL_RED, SIDE_GREEN, SIDE_YELLOW, ALL_RED, MAIN_GREEN};
    phase_t exp_p = MAIN_GREEN;
    logic [11:0] exp_l;
    int k = 0;
    reset_dut();
    for (int c = 0; c <= 110; c++) begin
      // Request sampled on the edges ending cycles 39 and 40.
      req_side = (c == 39 || c == 40);
      if (k < 7 && c == chg_c[k]) begin exp_p = chg_p[k]; k++; end
      exp_l = lamp_decode(exp_p);
      tests++;
      if (phase !== exp_p || {M1, M2, MT, S} !== exp_l) begin
        fails++;
        $display("[TB] FAIL side_seq cycle %0d: phase=%0d lamps=%h, expected phase=%0d lamps=%h",
                 c, phase, {M1, M2, MT, S}, exp_p, exp_l);
      end
      if (c == 40 || c == 53) begin
        tests++;
        if (side_pending !== (c == 40)) begin
          fails++;
          $display("[TB] FAIL side_pending cycle %0d: got %b, expected %b", c, side_pending, (c == 40));
        end
      end
      if (c == 53) begin
        tests++;
        if (S !== 3'b001 || M1 !== 3'b100) begin
          fails++;
          $display("[TB] FAIL side_green_lamps: S=%b M1=%b, expected 001 100", S, M1);
        end
      end
      next_cycle();
    end
    req_side = 1'b0;
  endtask

  task automatic test_both();
    int     chg_c[9] = '{0, 28, 36, 56, 64, 68, 80, 88, 92};
    phase_t chg_p[9] = '{MAIN_GREEN, M2_YELLOW, TURN_GREEN, TURN_YELLOW, ALL_RED,
                         SIDE_GREEN, SIDE_YELLOW, ALL_RED, MAIN_GREEN};
    phase_t exp_p = MAIN_GREEN;
    logic [11:0] exp_l;
    int k = 0;
    reset_dut();
    for (int c = 0; c <= 125; c++) begin
      req_turn = (c == 2);
      req_side = (c == 2);
      if (k < 9 && c == chg_c[k]) begin exp_p = chg_p[k]; k++; end
      exp_l = lamp_decode(exp_p);
      tests++;
      if (phase !== exp_p || {M1, M2, MT, S} !== exp_l) begin
        fails++;
        $display("[TB] FAIL both_seq cycle %0d: phase=%0d lamps=%h, expected phase=%0d lamps=%h",
                 c, phase, {M1, M2, MT, S}, exp_p, exp_l);
      end
      if (c == 67 || c == 68) begin
        tests++;
        if (side_pending !== (c == 67)) begin
          fails++;
          $display("[TB] FAIL both_side_pending cycle %0d: got %b, expected %b", c, side_pending, (c == 67));
        end
      end
      if (c == 35 || c == 36) begin
        tests++;
        if (turn_pending !== (c == 35)) begin
          fails++;
          $display("[TB] FAIL both_turn_pending cycle %0d: got %b, expected %b", c, turn_pending, (c == 35));
        end
      end
      next_cycle();
    end
    req_turn = 1'b0;
    req_side = 1'b0;
  endtask

  task automatic test_back_to_back();
    int     chg_c[12] = '{0, 28, 36, 56, 64, 68, 80, 88, 92, 120, 128, 132};
    phase_t chg_p[12] = '{MAIN_GREEN, M2_YELLOW, TURN_GREEN, TURN_YELLOW, ALL_RED, SIDE_GREEN,
                          SIDE_YELLOW, ALL_RED, MAIN_GREEN, MAIN_YELLOW, ALL_RED, SIDE_GREEN};
    phase_t exp_p = MAIN_GREEN;
    logic [11:0] exp_l;
    int k = 0;
    logic exp_sp;
    reset_dut();
    for (int c = 0; c <= 140; c++) begin
      req_turn = (c >= 2 && c <= 55);
      req_side = (c == 2) || (c >= 70 && c <= 75) || (c == 82);
      if (k < 12 && c == chg_c[k]) begin exp_p = chg_p[k]; k++; end
      exp_l = lamp_decode(exp_p);
      tests++;
      if (phase !== exp_p || {M1, M2, MT, S} !== exp_l) begin
        fails++;
        $display("[TB] FAIL b2b_seq cycle %0d: phase=%0d lamps=%h, expected phase=%0d lamps=%h",
                 c, phase, {M1, M2, MT, S}, exp_p, exp_l);
      end
      if (c >= 36) begin
        tests++;
        if (turn_pending !== 1'b0) begin
          fails++;
          $display("[TB] FAIL b2b_turn_ignored cycle %0d: turn_pending=%b, expected 0", c, turn_pending);
        end
      end
      if (c >= 68) begin
        exp_sp = (c >= 83 && c < 132);
        tests++;
        if (side_pending !== exp_sp) begin
          fails++;
          $display("[TB] FAIL b2b_side_pending cycle %0d: got %b, expected %b", c, side_pending, exp_sp);
        end
      end
      next_cycle();
    end
    req_turn = 1'b0;
    req_side = 1'b0;
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int c = 0; c < 40; c++) begin
      req_turn = (c == 2);
      req_side = (c == 2);
      next_cycle();
    end
    req_turn = 1'b0;
    req_side = 1'b0;
    tests++;
    if (phase !== 3'd2 || side_pending !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pre_reset_state: phase=%0d side_pending=%b, expected 2 1", phase, side_pending);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (phase !== 3'd0 || {M1, M2, MT, S} !== 12'b001_001_100_100 || side_pending !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: phase=%0d lamps=%b%b%b%b side_pending=%b, expected 0 001001100100 0",
               phase, M1, M2, MT, S, side_pending);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      req_side = (c == 0);
      tests++;
      if (phase !== ((c >= 28) ? 3'd4 : 3'd0)) begin
        fails++;
        $display("[TB] FAIL post_reset_min_green cycle %0d: phase=%0d, expected %0d",
                 c, phase, (c >= 28) ? 4 : 0);
      end
      next_cycle();
    end
    req_side = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_turn();
    test_side();
    test_both();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
